segment_decoder: RTL
====================

// Module: segment_decoder
// PURPOSE
//  Reverse of the digit->segment encoder: watches a time-multiplexed 9-bit
//  segment bus plus a digit select, turns each segment code back into a 4-bit
//  digit value (0-9, 10=blank), debounces it per digit, and flags illegal codes.
//  Used as a readback checker on the two-digit display path of the reaction timer.
// PARAMETERS
//  STABLE_CNT  4  consecutive identical legal samples required to commit (legal range 1..15)
//  CNT_W       4  width of the per-digit stability counters (must hold STABLE_CNT)
// PORTS
//  clk       in   1  system clock, rising edge
//  rst_n     in   1  asynchronous reset, active low
//  sample    in   1  qualifies seg_bus/dig_sel this cycle
//  dig_sel   in   2  one-hot digit select: 01=digit 1, 10=digit 2
//  seg_bus   in   9  segment code: [6:0]=a..g, [7]=dp, [8]=blank marker
//  data_1    out  4  committed value, digit 1 (0-9, 10=blank)
//  data_2    out  4  committed value, digit 2
//  valid_1   out  1  data_1 has been committed at least once since reset
//  valid_2   out  1  data_2 has been committed at least once since reset
//  upd_1     out  1  1-cycle pulse: data_1 committed with a new value or for the first time
//  upd_2     out  1  1-cycle pulse: data_2 committed with a new value or for the first time
//  err       out  1  1-cycle pulse: illegal code or illegal dig_sel sampled
// BEHAVIOUR
//  - Reset (async, rst_n=0): data_x=4'd10, valid_x=0, upd_x=0, err=0,
//    cand_x=4'hF, cnt_x=0. Reset deasserted mid-stream: decoding restarts from scratch.
//  - Lookup, exact match only:
//    3f->0, 06->1, 5b->2, 4f->3, 66->4, 6d->5, 7d->6, 07->7, 7f->8, 6f->9, 100->10.
//    Any other code is illegal.
//  - Ignored: sample=0, or sample=1 with dig_sel=00. No state change, no pulse.
//  - sample=1 with dig_sel=11: err pulses; both digits keep all state.
//  - Per digit x, when sample=1 and dig_sel selects x:
//    - Illegal code: err pulses; cand_x=F, cnt_x=0; data_x and valid_x hold.
//    - Legal code d, d!=cand_x: cand_x=d, cnt_x=1.
//    - Legal code d, d==cand_x, cnt_x<STABLE_CNT: cnt_x increments.
//    - Legal code d, d==cand_x, cnt_x==STABLE_CNT: counter saturates; no further commit.
//  - Commit: the edge on which cnt_x becomes STABLE_CNT.
//    - data_x=cand_x and valid_x=1, both registered on that edge.
//    - upd_x is high for the following cycle only when the value changed or valid_x was 0.
//  - Latency: data_x is visible the cycle after the STABLE_CNT-th matching sample.
//    With STABLE_CNT=1 this is the cycle after the first sample.
//  - Digits are independent: a digit-1 sample never touches digit-2 state.
//  - Outputs are registered, with no combinational path from inputs to outputs.
//  - upd_x and err are exactly one cycle wide. Back-to-back events give back-to-back pulses.
// CONFIGURATION
//  SEG_DP_EN defined:
//    - seg_bus[7] is masked before lookup.
//    - Extra ports dp_1/dp_2 (out, 1): dp bit captured with each commit; reset 0.
//    - A dp change alone with the same digit value is not a new value (no upd_x).
//  SEG_DP_EN undefined:
//    - No dp ports; any code with seg_bus[7]=1 is illegal.
// TESTING
//  1. Reset; no samples -> data_1=data_2=10, valid_x=0, upd_x=0, err=0 indefinitely.
//  2. STABLE_CNT=4; 4 samples dig_sel=01, seg_bus=0x5b
//     -> data_1=2, valid_1=1 the cycle after the 4th sample; one upd_1 pulse;
//     a 5th sample gives no pulse; digit 2 unchanged.
//  3. Digit 2: 0x4f,0x4f,0x66,0x66,0x66,0x66
//     -> no commit on 3; data_2=4 after the 6th sample; upd_2 once.
//  4. Digit 1 committed =7 (0x07); then 0x07,0x07,0x55,0x07
//     -> err pulses on 0x55; counter restarts; data_1 stays 7.
//     dig_sel=11 sample -> err pulse only.
//  5. Digit 1 at 3 of 4 matches of 0x6f; assert rst_n=0 asynchronously between edges
//     -> outputs return to reset values immediately; after release, 4 fresh samples are needed to commit 9.
//  6. SEG_DP_EN: digit 1 0xbf x4 -> data_1=0, dp_1=1.
//     Without SEG_DP_EN: 0xbf -> err each sample, no commit.

Source files
------------

// File: rtl/segment_decoder.sv
// segment_decoder: turns a time-multiplexed segment bus back into debounced digit values.
// Optional feature: define SEG_DP_EN to mask seg_bus[7] before lookup and expose dp_1/dp_2.
module segment_decoder #(
   parameter int STABLE_CNT = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample,
   input  logic [1:0] dig_sel,
   input  logic [8:0] seg_bus,
   output logic [3:0] data_1,
   output logic [3:0] data_2,
   output logic       valid_1,
   output logic       valid_2,
   output logic       upd_1,
   output logic       upd_2,
`ifdef SEG_DP_EN
   output logic       dp_1,
   output logic       dp_2,
`endif
   output logic       err
);

   localparam logic [CNT_W-1:0] STB = CNT_W'(STABLE_CNT);

   logic [8:0]            code;
   logic                  legal;
   logic [3:0]            digit;
   logic [1:0][3:0]       data_q, data_d, cand_q, cand_d;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            valid_q, valid_d, upd_q, upd_d;
   logic                  err_q, err_d;
`ifdef SEG_DP_EN
   logic [1:0]            dp_q, dp_d;
`endif

   // Exact-match lookup of the segment code; blank marker decodes to 10
   always_comb begin
      code = seg_bus;
`ifdef SEG_DP_EN
      code[7] = 1'b0;
`endif
      legal = 1'b1;
      digit = 4'd0;
      case (code)
         9'h03f: digit = 4'd0;
         9'h006: digit = 4'd1;
         9'h05b: digit = 4'd2;
         9'h04f: digit = 4'd3;
         9'h066: digit = 4'd4;
         9'h06d: digit = 4'd5;
         9'h07d: digit = 4'd6;
         9'h007: digit = 4'd7;
         9'h07f: digit = 4'd8;
         9'h06f: digit = 4'd9;
         9'h100: digit = 4'd10;
         default: legal = 1'b0;
      endcase
   end

   // Per-digit candidate tracking, stability counting and commit decision
   always_comb begin
      data_d  = data_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      upd_d   = '0;
`ifdef SEG_DP_EN
      dp_d    = dp_q;
`endif
      err_d   = sample && ((&dig_sel) || ((^dig_sel) && !legal));
      for (int x = 0; x < 2; x++) begin
         if (sample && (^dig_sel) && dig_sel[x]) begin
            if (!legal) begin
               cand_d[x] = 4'hF;
               cnt_d[x]  = '0;
            end else if (digit != cand_q[x]) begin
               cand_d[x] = digit;
               cnt_d[x]  = CNT_W'(1);
            end else if (cnt_q[x] != STB) begin
               cnt_d[x]  = cnt_q[x] + CNT_W'(1);
            end
            if (legal && cnt_d[x] == STB && (digit != cand_q[x] || cnt_q[x] != STB)) begin
               data_d[x]  = digit;
               valid_d[x] = 1'b1;
               upd_d[x]   = !valid_q[x] || data_q[x] != digit;
`ifdef SEG_DP_EN
               dp_d[x]    = seg_bus[7];
`endif
            end
         end
      end
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= {2{4'd10}};
         cand_q  <= {2{4'hF}};
         cnt_q   <= '0;
         valid_q <= '0;
         upd_q   <= '0;
         err_q   <= 1'b0;
`ifdef SEG_DP_EN
         dp_q    <= '0;
`endif
      end else begin
         data_q  <= data_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
`ifdef SEG_DP_EN
         dp_q    <= dp_d;
`endif
      end
   end

   assign data_1  = data_q[0];
   assign data_2  = data_q[1];
   assign valid_1 = valid_q[0];
   assign valid_2 = valid_q[1];
   assign upd_1   = upd_q[0];
   assign upd_2   = upd_q[1];
   assign err     = err_q;
`ifdef SEG_DP_EN
   assign dp_1    = dp_q[0];
   assign dp_2    = dp_q[1];
`endif

endmodule
